mac_seq: RTL and testbench
==========================

// Module: mac_seq
// PURPOSE
//  Sequencer for one signed 4x4->12 MAC: runs one LEN-element dot product per job.
//  Clears the accumulator, streams operand pairs in through a valid/ready port, drains the MAC pipeline,
//  then holds the result under a valid/ready handshake. Sits between the host/operand source and the mac instance.
// PARAMETERS
//  DW       4   operand width, signed (IN and W)
//  ACC_W    12  accumulator/result width, signed
//  MAX_LEN  16  max elements per job; constraint (2**(DW-1))**2 * MAX_LEN <= 2**(ACC_W-1)-1, so no overflow is possible
//  LEN_W    5   width of len port; LEN_W >= clog2(MAX_LEN+1)
//  MAC_LAT  1   edges from a pair on mac_in/mac_w until mac_out includes it
// PORTS
//  clk        in  1      clock, all logic on rising edge
//  rstb       in  1      synchronous reset, active-high (1 = reset)
//  start      in  1      job request, sampled only in IDLE
//  len        in  LEN_W  element count, sampled with start
//  busy       out 1      1 in every state except IDLE
//  err        out 1      1-cycle pulse: start with len==0 or len>MAX_LEN
//  in_valid   in  1      operand pair valid
//  in_ready   out 1      1 only in RUN
//  in_a       in  DW     signed activation
//  in_w       in  DW     signed weight
//  res_valid  out 1      result valid, held until accepted
//  res_ready  in  1      result consumer ready
//  res_data   out ACC_W  signed dot-product result
//  mac_in     out DW     to mac IN (registered)
//  mac_w      out DW     to mac W (registered)
//  mac_clr_n  out 1      to mac active-low clear (registered)
//  mac_out    in  ACC_W  from mac OUT
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, err=0, in_ready=0, res_valid=0, res_data=0, mac_in=0, mac_w=0, mac_clr_n=0.
//    Reset overrides all other inputs; a job in flight is discarded with no result and no err.
//  - IDLE: mac_clr_n=1. If start and 1<=len<=MAX_LEN: latch len, cnt=0, go to CLEAR.
//    If start with a bad len: err=1 for one cycle, stay in IDLE.
//  - CLEAR (1 cycle): mac_clr_n=0, mac_in=mac_w=0. Go to RUN.
//  - RUN: in_ready=1. A pair is accepted on in_valid&in_ready:
//    mac_in<=in_a, mac_w<=in_w, cnt<=cnt+1. With no accept, mac_in=mac_w<=0, so bubbles add 0.
//    Leave RUN on the edge that accepts pair number len; go to DRAIN with dcnt=0.
//  - DRAIN (MAC_LAT+1 cycles): in_ready=0. mac_in/mac_w are 0 from the first DRAIN edge on.
//    On the last DRAIN edge, res_data<=mac_out and res_valid<=1. Go to DONE.
//  - DONE: res_valid=1, res_data stable. On res_valid&res_ready, res_valid<=0 and go to IDLE.
//    Starting the next job needs at least one IDLE cycle.
//  - start outside IDLE is ignored: no err, no queueing.
//  - in_valid is don't-care outside RUN, and no pair is consumed.
//  - Arithmetic is done in the mac only. The controller does not extend or saturate; res_data is mac_out verbatim.
//  - Latency, no bubbles: first res_valid=1 is 1+len+MAC_LAT+1 edges after the edge that sampled start.
//  - cnt and dcnt are sized from LEN_W; they cannot wrap because len<=MAX_LEN.
// STRUCTURE
//  - Shared package mac_pkg: DW, ACC_W, MAX_LEN, MAC_LAT defaults and the state enum (IDLE, CLEAR, RUN, DRAIN, DONE).
//  - Single flat module; no sub-modules. The mac is instantiated alongside this block, not inside it.
// TESTING (bench instantiates mac_seq plus mac; MAC_LAT=1)
//  1. len=9, pairs (4,3)(-1,2)(2,-2)(1,1)(-3,1)(3,-1)(-2,2)(2,-3)(-4,-4), no gaps
//     -> res_data=7; res_valid rises exactly 12 edges after start.
//  2. len=11, pairs (1,1)(-1,-1)(2,2)(-2,-2)(3,3)(-3,-3)(4,4)(-4,-4)(1,-1)(-1,1)(2,-2), in_valid toggling every cycle
//     -> res_data=54; exactly 11 accepts counted.
//  3. start with len=0, then with len=17 -> err is a 1-cycle pulse each time; busy stays 0; mac_clr_n stays 1.
//  4. res_ready=0 for 5 cycles in DONE, with start pulsed
//     -> res_valid and res_data hold; no err; one result delivered; then IDLE.
//  5. rstb=1 after 4 accepted pairs -> next cycle all reset values, including mac_clr_n=0.
//     Then len=2, (7,7)(-8,-8) -> res_data=113.
//  6. len=16, all pairs (-8,-8) -> res_data=1024, no wrap.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared parameters and controller state encoding for the MAC sequencer.
package mac_pkg;
    localparam int DW      = 4;
    localparam int ACC_W   = 12;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int MAC_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/mac_seq_if.sv
// Host-side bundle of the MAC sequencer: job control, operand stream, result.
interface mac_seq_if;
    import mac_pkg::*;

    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    busy;
    logic                    err;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DW-1:0]    in_a;
    logic signed [DW-1:0]    in_w;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [ACC_W-1:0] res_data;

    modport master (
        output start, len, in_valid, in_a, in_w, res_ready,
        input  busy, err, in_ready, res_valid, res_data
    );

    modport slave (
        input  start, len, in_valid, in_a, in_w, res_ready,
        output busy, err, in_ready, res_valid, res_data
    );
endinterface

// File: rtl/mac.sv
// Signed multiply-accumulate with synchronous active-low clear; one edge
// from operands to accumulated output.
module mac
    import mac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_n,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    w,
    output logic signed [ACC_W-1:0] acc
);
    logic signed [2*DW-1:0] prod;

    assign prod = a * w;

    always_ff @(posedge clk) begin
        if (rst || !clr_n) begin
            acc <= '0;
        end else begin
            acc <= acc + ACC_W'(prod);
        end
    end
endmodule

// File: rtl/mac_seq.sv
// Job sequencer for an external MAC: clear, stream len pairs, drain the
// MAC pipeline and hold the dot product until the consumer takes it.
module mac_seq
    import mac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstb,
    mac_seq_if.slave                host,
    output logic signed [DW-1:0]    mac_in,
    output logic signed [DW-1:0]    mac_w,
    output logic                    mac_clr_n,
    input  logic signed [ACC_W-1:0] mac_out
);
    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] dcnt;
    logic             len_ok;
    logic             accept;

    assign len_ok = (host.len != '0) && (host.len <= LEN_W'(MAX_LEN));
    assign accept = host.in_valid && host.in_ready;

    always_ff @(posedge clk) begin
        if (rstb) begin
            state          <= IDLE;
            len_q          <= '0;
            cnt            <= '0;
            dcnt           <= '0;
            host.busy      <= 1'b0;
            host.err       <= 1'b0;
            host.in_ready  <= 1'b0;
            host.res_valid <= 1'b0;
            host.res_data  <= '0;
            mac_in         <= '0;
            mac_w          <= '0;
            mac_clr_n      <= 1'b0;
        end else begin
            host.err <= 1'b0;
            unique case (state)
                IDLE: begin
                    mac_clr_n <= 1'b1;
                    if (host.start && len_ok) begin
                        len_q     <= host.len;
                        cnt       <= '0;
                        state     <= CLEAR;
                        host.busy <= 1'b1;
                        mac_clr_n <= 1'b0;
                        mac_in    <= '0;
                        mac_w     <= '0;
                    end else if (host.start) begin
                        host.err <= 1'b1;
                    end
                end
                CLEAR: begin
                    state         <= RUN;
                    host.in_ready <= 1'b1;
                    mac_clr_n     <= 1'b1;
                    mac_in        <= '0;
                    mac_w         <= '0;
                end
                RUN: begin
                    // Idle cycles feed zeros so the MAC adds nothing.
                    if (accept) begin
                        mac_in <= host.in_a;
                        mac_w  <= host.in_w;
                        cnt    <= cnt + LEN_W'(1);
                        if (cnt + LEN_W'(1) == len_q) begin
                            state         <= DRAIN;
                            host.in_ready <= 1'b0;
                            dcnt          <= '0;
                        end
                    end else begin
                        mac_in <= '0;
                        mac_w  <= '0;
                    end
                end
                DRAIN: begin
                    mac_in <= '0;
                    mac_w  <= '0;
                    dcnt   <= dcnt + LEN_W'(1);
                    if (dcnt == LEN_W'(MAC_LAT)) begin
                        host.res_data  <= mac_out;
                        host.res_valid <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (host.res_ready) begin
                        host.res_valid <= 1'b0;
                        host.busy      <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq driving a mac instance: vector table,
// hand-written corner sequences and random jobs against a dot-product model.
module tb_mac_seq;
    import mac_pkg::*;

    typedef struct {
        int          len;
        logic [63:0] a;
        logic [63:0] w;
        bit          gaps;
        int          exp;
    } vec_t;

    logic clk = 1'b0;
    logic rstb = 1'b1;
    logic signed [DW-1:0]    mac_in;
    logic signed [DW-1:0]    mac_w;
    logic                    mac_clr_n;
    logic signed [ACC_W-1:0] mac_out;

    always #5 clk = ~clk;

    mac_seq_if bus ();

    mac_seq dut (
        .clk       (clk),
        .rstb      (rstb),
        .host      (bus),
        .mac_in    (mac_in),
        .mac_w     (mac_w),
        .mac_clr_n (mac_clr_n),
        .mac_out   (mac_out)
    );

    mac u_mac (
        .clk   (clk),
        .rst   (rstb),
        .clr_n (mac_clr_n),
        .a     (mac_in),
        .w     (mac_w),
        .acc   (mac_out)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model(int n, logic [63:0] a, logic [63:0] w);
        int s = 0;
        for (int i = 0; i < n; i++)
            s += int'($signed(a[i*4+:4])) * int'($signed(w[i*4+:4]));
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(int n);
        bus.start = 1'b1;
        bus.len   = n[LEN_W-1:0];
        step();
        bus.start = 1'b0;
    endtask

    // Streams pairs until res_valid rises; lat counts edges after the start edge.
    task automatic feed(int n, logic [63:0] a, logic [63:0] w, bit gaps,
                        output int lat, output int acc);
        int idx = 0;
        bit tog = 1'b1;
        bit fire;
        lat = 0;
        acc = 0;
        for (int c = 0; c < 200; c++) begin
            bus.in_valid = (idx < n) && (!gaps || tog);
            bus.in_a = '0;
            bus.in_w = '0;
            if (idx < n) begin
                bus.in_a = a[idx*4+:4];
                bus.in_w = w[idx*4+:4];
            end
            fire = bus.in_valid && bus.in_ready;
            step();
            lat++;
            tog = !tog;
            if (fire) begin
                idx++;
                acc++;
            end
            if (bus.res_valid) break;
        end
        bus.in_valid = 1'b0;
        chk("res_valid_rise", bus.res_valid, 1);
    endtask

    task automatic take(output int r);
        r = bus.res_data;
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("res_valid_drop", bus.res_valid, 0);
        chk("busy_after_take", bus.busy, 0);
    endtask

    task automatic run_vec(string nm, vec_t v);
        int lat, acc, r;
        start_job(v.len);
        feed(v.len, v.a, v.w, v.gaps, lat, acc);
        take(r);
        chk({nm, "_res"}, r, v.exp);
        if (v.gaps) chk({nm, "_accepts"}, acc, v.len);
        else chk({nm, "_latency"}, lat, v.len + 3);
        step();
    endtask

    task automatic chk_reset(string nm);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_err"}, bus.err, 0);
        chk({nm, "_in_ready"}, bus.in_ready, 0);
        chk({nm, "_res_valid"}, bus.res_valid, 0);
        chk({nm, "_res_data"}, bus.res_data, 0);
        chk({nm, "_mac_in_w"}, {mac_in, mac_w}, 0);
        chk({nm, "_mac_clr_n"}, mac_clr_n, 0);
    endtask

    vec_t tbl[6];
    vec_t v;
    int r;

    initial begin
        tbl[0] = '{9,  64'h0000_000C_2E3D_12F4, 64'h0000_000C_D2F1_1E23, 1'b0, 7};
        tbl[1] = '{11, 64'h0000_02F1_C4D3_E2F1, 64'h0000_0E1F_C4D3_E2F1, 1'b1, 54};
        tbl[2] = '{16, 64'h8888_8888_8888_8888, 64'h8888_8888_8888_8888, 1'b0, 1024};
        tbl[3] = '{1,  64'h0000_0000_0000_0007, 64'h0000_0000_0000_0007, 1'b0, 49};
        tbl[4] = '{16, 64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777, 1'b0, 784};
        tbl[5] = '{16, 64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777, 1'b1, -896};

        bus.start = 0; bus.len = '0; bus.in_valid = 0;
        bus.in_a = '0; bus.in_w = '0; bus.res_ready = 0;
        rstb = 1'b1;
        step();
        step();
        chk_reset("reset");
        rstb = 1'b0;
        step();
        chk("idle_clr_n", mac_clr_n, 1);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Bad lengths pulse err without leaving IDLE.
        for (int k = 0; k < 2; k++) begin
            bus.start = 1'b1;
            bus.len = (k == 0) ? 5'd0 : 5'd17;
            step();
            bus.start = 1'b0;
            chk("err_pulse", bus.err, 1);
            chk("err_busy", bus.busy, 0);
            chk("err_clr_n", mac_clr_n, 1);
            step();
            chk("err_clear", bus.err, 0);
            chk("err_idle_busy", bus.busy, 0);
        end

        // Result held under backpressure; start in DONE is ignored.
        begin
            int lat, acc;
            start_job(9);
            feed(9, tbl[0].a, tbl[0].w, 1'b0, lat, acc);
            for (int k = 0; k < 5; k++) begin
                bus.start = (k == 2);
                bus.len = 5'd3;
                step();
                chk("hold_valid", bus.res_valid, 1);
                chk("hold_data", bus.res_data, 7);
                chk("hold_err", bus.err, 0);
            end
            bus.start = 1'b0;
            take(r);
            chk("hold_res", r, 7);
            step();
            chk("no_queue_busy", bus.busy, 0);
            chk("no_queue_ready", bus.in_ready, 0);
        end

        // Reset mid-job discards it.
        start_job(9);
        step();
        chk("run_ready", bus.in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a = tbl[0].a[k*4+:4];
            bus.in_w = tbl[0].w[k*4+:4];
            step();
        end
        bus.in_valid = 1'b0;
        rstb = 1'b1;
        step();
        chk_reset("midjob_reset");
        rstb = 1'b0;
        step();
        v = '{2, 64'h87, 64'h87, 1'b0, 113};
        run_vec("post_reset", v);

        for (int i = 0; i < 10; i++) begin
            v.len  = $urandom_range(1, MAX_LEN);
            v.a    = {$urandom, $urandom};
            v.w    = {$urandom, $urandom};
            v.gaps = $urandom_range(0, 1);
            v.exp  = model(v.len, v.a, v.w);
            run_vec($sformatf("rand%0d", i), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
